uart_rx_8n1: RTL and testbench
==============================

UART_RX_8N1 -- requirements
Module: uart_rx_8n1

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1250, clk cycles per bit (12 MHz / 9600 baud); legal range 16..65535.
REQ-002 SHALL have port clk  input  1  system clock, 12 MHz from SB_HFOSC; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rx  input  1  serial line, asynchronous to clk, idle high.
REQ-005 SHALL have port rxbyte  output  8  last received byte, valid while rx_valid high.
REQ-006 SHALL have port rx_valid  output  1  byte available; held until consumed.
REQ-007 SHALL have port rx_ready  input  1  consumer accepts rxbyte when rx_valid and rx_ready are both high on a rising edge.
REQ-008 SHALL have port framing_error  output  1  one-cycle pulse; stop bit sampled low.
REQ-009 SHALL have port overrun  output  1  one-cycle pulse; completed byte dropped because the previous byte was not yet consumed.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rx_s; 2-cycle input latency.
REQ-011 SHALL implement states IDLE, START, DATA, STOP, BREAK; baud counter width = clog2(CLKS_PER_BIT).
REQ-012 IDLE: on rx_s = 0 go to START and clear the baud counter.
REQ-013 START: at count CLKS_PER_BIT/2 (integer divide) sample the line; 0 -> DATA with counter cleared; 1 -> false start, back to IDLE with no output.
REQ-014 DATA: sample at each count CLKS_PER_BIT-1 (mid-bit); 8 samples shifted LSB first; after the 8th sample go to STOP.
REQ-015 STOP: sample at count CLKS_PER_BIT-1; 1 -> byte complete, go to IDLE; 0 -> framing_error pulse, no byte delivered, go to BREAK.
REQ-016 BREAK: remain until rx_s = 1, then go to IDLE; a held-low line yields exactly one framing_error.
REQ-017 On byte complete with rx_valid low, or with rx_valid and rx_ready both high that cycle: rxbyte loads on the next edge and rx_valid is high.
REQ-018 On byte complete with rx_valid high and rx_ready low: rxbyte and rx_valid are unchanged, overrun pulses one cycle, the new byte is discarded.
REQ-019 rx_valid SHALL clear on the edge where rx_valid and rx_ready are both high, unless REQ-017 reloads it in that same cycle.
REQ-020 rxbyte SHALL NOT change while rx_valid is high except via REQ-017.
REQ-021 Latency: rx_valid rises 1 cycle after the stop-bit sample edge; that is about 9.5*CLKS_PER_BIT + 3 cycles after the rx falling edge.
REQ-022 The receiver SHALL accept a new start bit in IDLE regardless of rx_valid; there is no back-pressure on the line.

Reset
REQ-023 On rst high at a rising edge: state = IDLE, counters = 0, shift register = 0, rxbyte = 0x00, rx_valid = 0, framing_error = 0, overrun = 0, synchronizer flops = 1.
REQ-024 Reset mid-frame SHALL abandon the frame with no output; the next frame after release SHALL receive correctly.

Configuration
REQ-025 Macro UART_RX_MAJORITY_EN defined: every start/data/stop sample SHALL be the 2-of-3 majority of rx_s at the sample point and the two preceding cycles.
REQ-026 Macro UART_RX_MAJORITY_EN undefined: each sample SHALL be the single rx_s value at the sample point; there is no extra logic.
REQ-027 Sample timing and latency SHALL be identical in both builds.

Verification
REQ-028 Send 0x44 at 1250 clk/bit, rx_ready held high -> rxbyte = 0x44, one-cycle rx_valid, no errors.
REQ-029 Send 0x55 then 0xA3 with rx_ready low -> rxbyte stays 0x55, rx_valid stays high, overrun pulses once at the end of 0xA3; pulse rx_ready -> rx_valid = 0.
REQ-030 Send a 300-cycle low glitch on an idle line -> no rx_valid, no framing_error, state back in IDLE.
REQ-031 Send 0x0F with the stop bit driven low, then hold low for 20000 cycles -> exactly one framing_error, no rx_valid; release high, send 0x81 -> rxbyte = 0x81.
REQ-032 Assert rst for one cycle during data bit 4 of 0x3C, then send 0xC3 -> no output from the first frame, rxbyte = 0xC3.
REQ-033 With UART_RX_MAJORITY_EN defined, send 0x00 with a one-cycle high glitch at each mid-bit point -> rxbyte = 0x00; without the macro -> rxbyte = 0xFF.

Source files
------------

// File: rtl/uart_rx_8n1.sv
// ---------------------------------------------------------------------------
// uart_rx_8n1
//
// Purpose:
//   8-N-1 UART receiver. The asynchronous serial line is brought into the
//   clk domain by a two-flop synchronizer. A five-state FSM finds the start
//   bit, confirms it at mid-bit, shifts in eight data bits LSB first, and
//   checks the stop bit. Each received byte is held in rxbyte with rx_valid
//   high until the consumer takes it (rx_valid && rx_ready on a rising edge).
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per bit period (16..65535, default 1250)
//
// Ports:
//   clk            in   system clock, all logic on the rising edge
//   rst            in   synchronous, active-high reset
//   rx             in   serial line, asynchronous to clk, idle high
//   rxbyte         out  [7:0] last received byte, valid while rx_valid high
//   rx_valid       out  byte available, held until consumed
//   rx_ready       in   consumer accepts rxbyte this edge when rx_valid high
//   framing_error  out  one-cycle pulse: stop bit sampled low
//   overrun        out  one-cycle pulse: completed byte dropped because the
//                       previous byte was still unconsumed
//
// Build option:
//   UART_RX_MAJORITY_EN  when defined, each start/data/stop sample is the
//                        2-of-3 majority of the synchronized line at the
//                        sample point and the two cycles before it. Sample
//                        timing and latency are the same in both builds.
// ---------------------------------------------------------------------------
module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rxbyte,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       framing_error,
    output logic       overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    // -----------------------------------------------------------------------
    // Input synchronizer. Both flops reset to the idle (high) line level so
    // that leaving reset never looks like a start bit.
    // -----------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_s_q;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value of its source; blocking here would collapse the
    // two synchronizer stages into one.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // -----------------------------------------------------------------------
    // Bit sampler: the value used at every start/data/stop decision point.
    // -----------------------------------------------------------------------
    logic sample_bit;

`ifdef UART_RX_MAJORITY_EN
    logic rx_h1_q;
    logic rx_h2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_h1_q <= 1'b1;
            rx_h2_q <= 1'b1;
        end else begin
            rx_h1_q <= rx_s_q;
            rx_h2_q <= rx_h1_q;
        end
    end

    // Vote over the current synchronized value and the two cycles before it,
    // so the decision still lands on the same edge as the single-sample build.
    assign sample_bit = (rx_s_q & rx_h1_q) | (rx_s_q & rx_h2_q) | (rx_h1_q & rx_h2_q);
`else
    assign sample_bit = rx_s_q;
`endif

    // -----------------------------------------------------------------------
    // Receive FSM and datapath registers
    // -----------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rxbyte_q, rxbyte_d;
    logic             rx_valid_q, rx_valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             byte_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            rxbyte_q   <= '0;
            rx_valid_q <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            rxbyte_q   <= rxbyte_d;
            rx_valid_q <= rx_valid_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    // Next-state logic. The baud counter runs in START, DATA and STOP and is
    // cleared at every sample point, so each bit period starts from zero.
    always_comb begin
        // NOTE: every signal assigned below gets a default first; a path that
        // leaves one unassigned would otherwise infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end

            // Re-check the line half a bit in; a high here was only a glitch.
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!sample_bit) begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Counting from the mid-start point, a full bit period lands on
            // the middle of each data bit. LSB arrives first, so shift right.
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {sample_bit, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (sample_bit) begin
                        byte_done = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // A line held low after a bad stop bit reports only once; wait
            // for it to return high before hunting for the next start bit.
            S_BREAK: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output handshake. A consumer taking the old byte in the same cycle a
    // new one completes frees the slot, so the new byte loads instead of
    // being dropped.
    always_comb begin
        rxbyte_d   = rxbyte_q;
        rx_valid_d = rx_valid_q;
        ovr_d      = 1'b0;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        if (byte_done) begin
            if (!rx_valid_q || rx_ready) begin
                rxbyte_d   = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign rxbyte        = rxbyte_q;
    assign rx_valid      = rx_valid_q;
    assign framing_error = ferr_q;
    assign overrun       = ovr_q;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_8n1
//
// Self-checking bench for uart_rx_8n1. Frames are generated cycle by cycle
// from a 10-bit 8-N-1 pattern. A negedge monitor records accepted bytes,
// error pulses and rx_valid activity; each scenario task compares those
// records with expectations worked out from the UART framing rules and the
// valid/ready handshake.
//
// A short bit period keeps the run small; the glitch length is scaled so it
// stays the same fraction of a bit as 300 cycles at 1250 cycles per bit.
// ---------------------------------------------------------------------------
module tb_uart_rx_8n1;

    localparam int CPB    = 125;
    localparam int HALF   = CPB / 2;
    localparam int GLITCH = (300 * CPB) / 1250;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rxbyte;
    logic       rx_valid;
    logic       framing_error;
    logic       overrun;

    always #5 clk = ~clk;

    uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .rxbyte        (rxbyte),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .framing_error (framing_error),
        .overrun       (overrun)
    );

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    int         cyc = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         ov_cyc = 0;
    int         valid_cyc = 0;
    int         rise_cnt = 0;
    int         rise_cyc = 0;
    int         hold_viol = 0;
    logic [7:0] got_acc[$];
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic       prev_rst = 1'b1;
    logic [7:0] prev_byte = 8'h00;
    int         fall_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (framing_error) fe_cnt <= fe_cnt + 1;
        if (overrun) begin
            ov_cnt <= ov_cnt + 1;
            ov_cyc <= cyc;
        end
        if (rx_valid) valid_cyc <= valid_cyc + 1;
        if (rx_valid && !prev_valid) begin
            rise_cnt <= rise_cnt + 1;
            rise_cyc <= cyc;
        end
        if (rx_valid && rx_ready) got_acc.push_back(rxbyte);
        // An unconsumed byte must stay put with rx_valid high.
        if (prev_valid && !prev_ready && !prev_rst && (!rx_valid || rxbyte !== prev_byte))
            hold_viol <= hold_viol + 1;
        prev_valid <= rx_valid;
        prev_ready <= rx_ready;
        prev_rst   <= rst;
        prev_byte  <= rxbyte;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        tick(n);
    endtask

    // Middle of data bit i, counted in cycles from the start-bit falling
    // edge: two synchronizer cycles plus the idle detection edge, then half a
    // bit to the start check, then one full bit per data bit.
    function automatic bit is_mid(input int c);
        for (int i = 0; i < 8; i++)
            if (c == (i + 1) * CPB + HALF + 1) return 1'b1;
        return 1'b0;
    endfunction

    // Drive start + 8 data (LSB first) + stop. glitch forces a one-cycle high
    // at each data mid-bit point. abort_at >= 0 pulses rst for one cycle at
    // that cycle of the frame and then abandons the frame with the line idle.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input bit glitch, input int abort_at);
        logic [9:0] bits;
        bits = {stop_bit, data, 1'b0};
        for (int c = 0; c < 10 * CPB; c++) begin
            if (c == abort_at) begin
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
                rx  = 1'b1;
                return;
            end
            if (c == 0) fall_cyc = cyc;
            rx = bits[c / CPB];
            if (glitch && is_mid(c)) rx = 1'b1;
            tick(1);
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset;
        rst = 1'b1;
        rx = 1'b1;
        rx_ready = 1'b0;
        tick(3);
        checks++;
        if (rxbyte !== 8'h00) begin
            errors++; $display("FAIL reset_rxbyte got %h want 00", rxbyte);
        end
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b want 0", rx_valid);
        end
        checks++;
        if (framing_error !== 1'b0) begin
            errors++; $display("FAIL reset_ferr got %b want 0", framing_error);
        end
        checks++;
        if (overrun !== 1'b0) begin
            errors++; $display("FAIL reset_overrun got %b want 0", overrun);
        end
        rst = 1'b0;
        tick(2 * CPB);
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++; $display("FAIL post_reset_valid got %b want 0", rx_valid);
        end
    endtask

    task automatic test_basic;
        int a0, v0, f0, o0, lat, want_lat;
        a0 = got_acc.size(); v0 = valid_cyc; f0 = fe_cnt; o0 = ov_cnt;
        rx_ready = 1'b1;
        send_frame(8'h44, 1'b1, 1'b0, -1);
        idle(2 * CPB);
        checks++;
        if (got_acc.size() - a0 != 1) begin
            errors++; $display("FAIL basic_count got %0d want 1", got_acc.size() - a0);
        end else begin
            checks++;
            if (got_acc[a0] !== 8'h44) begin
                errors++; $display("FAIL basic_byte got %h want 44", got_acc[a0]);
            end
        end
        checks++;
        if (valid_cyc - v0 != 1) begin
            errors++; $display("FAIL basic_valid_len got %0d want 1", valid_cyc - v0);
        end
        checks++;
        if (fe_cnt != f0 || ov_cnt != o0) begin
            errors++; $display("FAIL basic_errors got fe %0d ov %0d want 0 0",
                               fe_cnt - f0, ov_cnt - o0);
        end
        lat = rise_cyc - fall_cyc;
        want_lat = (19 * CPB) / 2 + 3;
        checks++;
        if (lat < want_lat - 2 || lat > want_lat + 2) begin
            errors++; $display("FAIL basic_latency got %0d want %0d+-2", lat, want_lat);
        end
    endtask

    task automatic test_overrun;
        int a0, o0, lat, want_lat;
        a0 = got_acc.size(); o0 = ov_cnt;
        rx_ready = 1'b0;
        send_frame(8'h55, 1'b1, 1'b0, -1);
        idle(CPB);
        send_frame(8'hA3, 1'b1, 1'b0, -1);
        idle(2 * CPB);
        checks++;
        if (rx_valid !== 1'b1 || rxbyte !== 8'h55) begin
            errors++; $display("FAIL ovr_held got valid %b byte %h want 1 55", rx_valid, rxbyte);
        end
        checks++;
        if (ov_cnt - o0 != 1) begin
            errors++; $display("FAIL ovr_pulses got %0d want 1", ov_cnt - o0);
        end
        lat = ov_cyc - fall_cyc;
        want_lat = (19 * CPB) / 2 + 3;
        checks++;
        if (lat < want_lat - 2 || lat > want_lat + 2) begin
            errors++; $display("FAIL ovr_timing got %0d want %0d+-2", lat, want_lat);
        end
        checks++;
        if (got_acc.size() != a0) begin
            errors++; $display("FAIL ovr_no_accept got %0d want 0", got_acc.size() - a0);
        end
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(2);
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++; $display("FAIL ovr_consume_valid got %b want 0", rx_valid);
        end
        checks++;
        if (got_acc.size() - a0 != 1) begin
            errors++; $display("FAIL ovr_consume_count got %0d want 1", got_acc.size() - a0);
        end else begin
            checks++;
            if (got_acc[a0] !== 8'h55) begin
                errors++; $display("FAIL ovr_consume_byte got %h want 55", got_acc[a0]);
            end
        end
    endtask

    task automatic test_glitch;
        int r0, f0, a0;
        logic [7:0] b;
        r0 = rise_cnt; f0 = fe_cnt;
        rx_ready = 1'b1;
        rx = 1'b0;
        tick(GLITCH);
        idle(3 * CPB);
        checks++;
        if (rise_cnt != r0 || fe_cnt != f0) begin
            errors++; $display("FAIL glitch_quiet got rises %0d fe %0d want 0 0",
                               rise_cnt - r0, fe_cnt - f0);
        end
        // The receiver must be back in IDLE: a normal frame right after works.
        b = 8'($urandom);
        a0 = got_acc.size();
        send_frame(b, 1'b1, 1'b0, -1);
        idle(2 * CPB);
        checks++;
        if (got_acc.size() - a0 != 1 || got_acc[got_acc.size() - 1] !== b) begin
            errors++; $display("FAIL glitch_recover got n %0d want 1 byte %h", got_acc.size() - a0, b);
        end
    endtask

    task automatic test_framing;
        int r0, f0, a0;
        r0 = rise_cnt; f0 = fe_cnt;
        rx_ready = 1'b1;
        send_frame(8'h0F, 1'b0, 1'b0, -1);
        tick(20000);
        checks++;
        if (fe_cnt - f0 != 1) begin
            errors++; $display("FAIL ferr_pulses got %0d want 1", fe_cnt - f0);
        end
        checks++;
        if (rise_cnt != r0) begin
            errors++; $display("FAIL ferr_no_valid got %0d want 0", rise_cnt - r0);
        end
        idle(2 * CPB);
        a0 = got_acc.size();
        send_frame(8'h81, 1'b1, 1'b0, -1);
        idle(2 * CPB);
        checks++;
        if (got_acc.size() - a0 != 1 || got_acc[got_acc.size() - 1] !== 8'h81) begin
            errors++; $display("FAIL ferr_recover got n %0d want 1 byte 81", got_acc.size() - a0);
        end
        checks++;
        if (fe_cnt - f0 != 1) begin
            errors++; $display("FAIL ferr_total got %0d want 1", fe_cnt - f0);
        end
    endtask

    task automatic test_reset_midframe;
        int r0, f0, a0;
        r0 = rise_cnt; f0 = fe_cnt;
        rx_ready = 1'b1;
        // Middle of data bit 4 of 0x3C.
        send_frame(8'h3C, 1'b1, 1'b0, 5 * CPB + HALF);
        idle(12 * CPB);
        checks++;
        if (rise_cnt != r0 || fe_cnt != f0) begin
            errors++; $display("FAIL rstmid_quiet got rises %0d fe %0d want 0 0",
                               rise_cnt - r0, fe_cnt - f0);
        end
        checks++;
        if (rxbyte !== 8'h00) begin
            errors++; $display("FAIL rstmid_rxbyte got %h want 00", rxbyte);
        end
        a0 = got_acc.size();
        send_frame(8'hC3, 1'b1, 1'b0, -1);
        idle(2 * CPB);
        checks++;
        if (got_acc.size() - a0 != 1 || got_acc[got_acc.size() - 1] !== 8'hC3) begin
            errors++; $display("FAIL rstmid_next got n %0d want 1 byte c3", got_acc.size() - a0);
        end
    endtask

    task automatic test_majority;
        int a0;
        logic [7:0] want;
`ifdef UART_RX_MAJORITY_EN
        want = 8'h00;
`else
        want = 8'hFF;
`endif
        a0 = got_acc.size();
        rx_ready = 1'b1;
        send_frame(8'h00, 1'b1, 1'b1, -1);
        idle(2 * CPB);
        checks++;
        if (got_acc.size() - a0 != 1 || got_acc[got_acc.size() - 1] !== want) begin
            errors++; $display("FAIL majority got n %0d want 1 byte %h", got_acc.size() - a0, want);
        end
    endtask

    // Random bytes, random stop-bit faults and random consumer readiness,
    // compared with a one-slot mailbox model of the receiver output.
    task automatic test_random;
        logic [7:0] exp_acc[$];
        bit         mdl_valid;
        logic [7:0] mdl_byte;
        int         exp_fe, exp_ov, a0, f0, o0, h0;
        logic [7:0] data;
        bit         ready, stop_ok;
        mdl_valid = 1'b0; mdl_byte = 8'h00; exp_fe = 0; exp_ov = 0;
        a0 = got_acc.size(); f0 = fe_cnt; o0 = ov_cnt; h0 = hold_viol;
        for (int n = 0; n < 8; n++) begin
            data    = 8'($urandom);
            ready   = 1'($urandom_range(0, 1));
            stop_ok = ($urandom_range(0, 3) != 0);
            rx_ready = ready;
            if (ready && mdl_valid) begin
                exp_acc.push_back(mdl_byte);
                mdl_valid = 1'b0;
            end
            send_frame(data, stop_ok, 1'b0, -1);
            idle(CPB);
            if (!stop_ok) exp_fe++;
            else if (ready) exp_acc.push_back(data);
            else if (!mdl_valid) begin
                mdl_valid = 1'b1;
                mdl_byte  = data;
            end else exp_ov++;
            checks++;
            if (rx_valid !== mdl_valid || (mdl_valid && rxbyte !== mdl_byte)) begin
                errors++; $display("FAIL rand_frame%0d got valid %b byte %h want %b %h",
                                   n, rx_valid, rxbyte, mdl_valid, mdl_byte);
            end
        end
        rx_ready = 1'b1;
        if (mdl_valid) exp_acc.push_back(mdl_byte);
        tick(2);
        checks++;
        if (got_acc.size() - a0 != exp_acc.size()) begin
            errors++; $display("FAIL rand_count got %0d want %0d", got_acc.size() - a0, exp_acc.size());
        end else begin
            for (int i = 0; i < exp_acc.size(); i++) begin
                checks++;
                if (got_acc[a0 + i] !== exp_acc[i]) begin
                    errors++; $display("FAIL rand_byte%0d got %h want %h", i, got_acc[a0 + i], exp_acc[i]);
                end
            end
        end
        checks++;
        if (fe_cnt - f0 != exp_fe || ov_cnt - o0 != exp_ov) begin
            errors++; $display("FAIL rand_errors got fe %0d ov %0d want %0d %0d",
                               fe_cnt - f0, ov_cnt - o0, exp_fe, exp_ov);
        end
        checks++;
        if (hold_viol != h0) begin
            errors++; $display("FAIL rand_hold got %0d want 0", hold_viol - h0);
        end
    endtask

    task automatic test_hold;
        checks++;
        if (hold_viol != 0) begin
            errors++; $display("FAIL hold_violations got %0d want 0", hold_viol);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_overrun;
        test_glitch;
        test_framing;
        test_reset_midframe;
        test_majority;
        test_random;
        test_hold;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
